// File: rtl/iqmap_multi.sv
// rtl/iqmap_multi.sv - multi-mode (BPSK/QPSK/16QAM) IQ symbol mapper fed from a show-ahead FIFO
//
// Purpose:
//   Pops DW-bit words from a show-ahead reader FIFO and serialises each word,
//   LSB first, into BPSK, QPSK or Gray-coded 16QAM symbols. One signed I/Q
//   sample pair is produced per enabled cycle while a word is being mapped.
//   Consecutive words are mapped with no bubble when the FIFO is not empty
//   at the word boundary.
//
// Ports:
//   CLK         in   1    clock, rising edge
//   RST_N       in   1    asynchronous active-low reset
//   ce          in   1    clock enable; all state holds while low
//   mode        in   2    0=BPSK, 1=QPSK, 2=16QAM, 3=QPSK; sampled at word load only
//   valid_i     in   1    reader FIFO not empty
//   reader_data in   DW   FIFO head word (show-ahead)
//   reader_en   out  1    pop strobe (combinational)
//   xr / xi     out  OW   signed I / Q sample (registered)
//   valid_o     out  1    xr/xi valid strobe (registered)
//   valid_raw   out  1    same timing as valid_o
//   raw         out  4    source bits of the current symbol, LSB aligned

module iqmap_multi #(
  parameter int DW    = 128,
  parameter int OW    = 11,
  parameter int LVL_B = 1023,
  parameter int LVL_Q = 724,
  parameter int LVL_3 = 970,
  parameter int LVL_1 = 323
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ce,
  input  logic [1:0]           mode,
  input  logic                 valid_i,
  input  logic [DW-1:0]        reader_data,
  output logic                 reader_en,
  output logic signed [OW-1:0] xr,
  output logic signed [OW-1:0] xi,
  output logic                 valid_o,
  output logic                 valid_raw,
  output logic [3:0]           raw
);

  localparam int CW = $clog2(DW);

  localparam logic [1:0] M_BPSK  = 2'd0;
  localparam logic [1:0] M_QPSK  = 2'd1;
  localparam logic [1:0] M_QAM16 = 2'd2;

  // Index of the last symbol of a word for each modulation.
  localparam logic [CW-1:0] LAST_B  = CW'(DW - 1);
  localparam logic [CW-1:0] LAST_Q  = CW'(DW / 2 - 1);
  localparam logic [CW-1:0] LAST_16 = CW'(DW / 4 - 1);

  localparam logic signed [OW-1:0] POS_B = OW'(LVL_B);
  localparam logic signed [OW-1:0] NEG_B = -OW'(LVL_B);
  localparam logic signed [OW-1:0] POS_Q = OW'(LVL_Q);
  localparam logic signed [OW-1:0] NEG_Q = -OW'(LVL_Q);
  localparam logic signed [OW-1:0] POS_3 = OW'(LVL_3);
  localparam logic signed [OW-1:0] NEG_3 = -OW'(LVL_3);
  localparam logic signed [OW-1:0] POS_1 = OW'(LVL_1);
  localparam logic signed [OW-1:0] NEG_1 = -OW'(LVL_1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         shift_q, shift_d;
  logic [CW-1:0]         count_q, count_d;
  logic [1:0]            mode_q,  mode_d;
  logic signed [OW-1:0]  xr_q,    xr_d;
  logic signed [OW-1:0]  xi_q,    xi_d;
  logic                  valid_q, valid_d;
  logic [3:0]            raw_q,   raw_d;

  logic [CW-1:0]         last_idx;
  logic                  at_last;
  logic [3:0]            sym_bits;
  logic signed [OW-1:0]  map_i;
  logic signed [OW-1:0]  map_q;
  logic [DW-1:0]         shift_next;
  logic [1:0]            mode_load;

  // Gray 16QAM axis: the high bit is the sign, the low bit picks the inner level.
  function automatic logic signed [OW-1:0] qam_level(input logic [1:0] b);
    if (b[1]) begin
      return b[0] ? POS_1 : POS_3;
    end else begin
      return b[0] ? NEG_1 : NEG_3;
    end
  endfunction

  // Symbol mapping from the low bits of the shift register, using the mode
  // latched with the word currently being serialised.
  always_comb begin
    last_idx   = LAST_Q;
    sym_bits   = '0;
    map_i      = '0;
    map_q      = '0;
    shift_next = shift_q >> 2;
    case (mode_q)
      M_BPSK: begin
        last_idx   = LAST_B;
        sym_bits   = {3'b000, shift_q[0]};
        map_i      = shift_q[0] ? POS_B : NEG_B;
        map_q      = '0;
        shift_next = shift_q >> 1;
      end
      M_QAM16: begin
        last_idx   = LAST_16;
        sym_bits   = shift_q[3:0];
        map_i      = qam_level(shift_q[1:0]);
        map_q      = qam_level(shift_q[3:2]);
        shift_next = shift_q >> 4;
      end
      default: begin
        last_idx   = LAST_Q;
        sym_bits   = {2'b00, shift_q[1:0]};
        map_i      = shift_q[0] ? POS_Q : NEG_Q;
        map_q      = shift_q[1] ? POS_Q : NEG_Q;
        shift_next = shift_q >> 2;
      end
    endcase
  end

  // Reserved mode 3 is folded into QPSK at load time so the datapath only
  // ever sees three encodings.
  always_comb begin
    case (mode)
      M_BPSK:  mode_load = M_BPSK;
      M_QAM16: mode_load = M_QAM16;
      default: mode_load = M_QPSK;
    endcase
  end

  assign at_last = (count_q == last_idx);

  // Pop when idle, or on the last symbol of the current word so the next
  // word starts on the very next cycle.
  always_comb begin
    reader_en = ce & valid_i &
                ((state_q == IDLE) | ((state_q == ACTIVE) & at_last));
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    mode_d  = mode_q;
    xr_d    = xr_q;
    xi_d    = xi_q;
    raw_d   = raw_q;
    valid_d = 1'b0;

    if (ce) begin
      if (state_q == ACTIVE) begin
        xr_d    = map_i;
        xi_d    = map_q;
        raw_d   = sym_bits;
        valid_d = 1'b1;
        shift_d = shift_next;
        count_d = count_q + CW'(1);
        if (at_last) begin
          state_d = IDLE;
        end
      end
      // A load overrides the end-of-word transition to IDLE.
      if (reader_en) begin
        shift_d = reader_data;
        mode_d  = mode_load;
        count_d = '0;
        state_d = ACTIVE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      mode_q  <= M_QPSK;
      xr_q    <= '0;
      xi_q    <= '0;
      valid_q <= 1'b0;
      raw_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      xr_q    <= xr_d;
      xi_q    <= xi_d;
      valid_q <= valid_d;
      raw_q   <= raw_d;
    end
  end

  assign xr        = xr_q;
  assign xi        = xi_q;
  assign raw       = raw_q;
  assign valid_o   = valid_q;
  assign valid_raw = valid_q;

endmodule

// File: doc/iqmap_multi.md
Name: iqmap_multi

Overview:
Parametrised, multi-mode IQ mapper. It pops DW-bit words from a show-ahead reader FIFO and serialises each word into BPSK, QPSK or 16QAM symbols. It emits one signed I/Q sample pair per enabled cycle. It replaces the fixed-QPSK mapper on the transmit side and feeds the matching demapper, whose inputs are xr/xi/valid_o.

Parameters:
DW, 128, input word width; must be a multiple of 4
OW, 11, signed output sample width
LVL_B, 1023, BPSK amplitude (+/-LVL_B on I; Q fixed at 0)
LVL_Q, 724, QPSK amplitude per axis
LVL_3, 970, 16QAM outer level
LVL_1, 323, 16QAM inner level

Ports:
CLK  in  1  clock; all registers on rising edge
RST_N  in  1  asynchronous, active-low reset
ce  in  1  clock enable; when low, all state holds
mode  in  2  0=BPSK, 1=QPSK, 2=16QAM, 3=reserved (treated as QPSK)
valid_i  in  1  reader FIFO not-empty; reader_data is valid while high
reader_data  in  DW  show-ahead FIFO head word
reader_en  out  1  pop strobe (combinational); word is consumed in the cycle it is high
xr  out  OW  signed I sample (registered)
xi  out  OW  signed Q sample (registered)
valid_o  out  1  xr/xi valid strobe (registered)
valid_raw  out  1  raw valid; identical timing to valid_o
raw  out  4  source bits of the current symbol, LSB-aligned, upper bits zero

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (RST_N).
- Reset values: xr=0, xi=0, valid_o=0, valid_raw=0, raw=0. Internal state: state=IDLE, shift register=0, count=0, latched mode=QPSK.
- Bits per symbol (bps): BPSK=1, QPSK=2, 16QAM=4. Symbols per word N = DW/bps (default 128/64/32).
- The mode input is latched only at word load. Changes to mode mid-word are ignored until the next load.
- reader_en = ce & valid_i & (state==IDLE | (state==ACTIVE & count==N-1)). It is never high while ce=0.
- On reader_en: shift register <= reader_data, mode latched, count <= 0, state <= ACTIVE.
- States:
  - IDLE: no symbol issued.
  - ACTIVE: each ce cycle maps the low bps bits of the shift register, shifts right by bps, and increments count.
  - At count==N-1: if reader_en fires, reload and stay ACTIVE (no bubble between words); otherwise go to IDLE.
- Bit order: symbols are taken LSB first. Symbol k uses bits [k*bps +: bps] of the word.
- BPSK mapping: b0=0 -> I=-LVL_B, b0=1 -> I=+LVL_B; Q=0.
- QPSK mapping: b0 selects I, b1 selects Q; 0 -> -LVL_Q, 1 -> +LVL_Q.
- 16QAM mapping (Gray): I from b1b0 and Q from b3b2, each as 00=-LVL_3, 01=-LVL_1, 11=+LVL_1, 10=+LVL_3.
- Arithmetic: levels are sign-extended or negated to OW bits, two's complement. No saturation is required because all levels are < 2^(OW-1).
- Latency: word popped at cycle t gives its first symbol on valid_o at cycle t+2 (with ce held high). Symbols then follow on consecutive ce cycles.
- Output registers update only when ce=1. In a ce=1 cycle with no symbol issued, valid_o/valid_raw <= 0 and xr/xi/raw hold.
- In a ce=0 cycle: valid_o/valid_raw <= 0, xr/xi/raw hold, shift register, count and state hold.
- Empty FIFO at a word boundary: go to IDLE with no output. A later valid_i resumes with the same t+2 latency.
- valid_i dropping mid-word has no effect, because the word is already captured.
- Reset mid-word: the partial word is discarded and not replayed. The first pop after RST_N deasserts starts at symbol 0 of the FIFO head.
- Reserved mode 3 behaves exactly as QPSK.

Test Plan:
- QPSK, DW=128, one word 0x...01 (low byte 0x01) -> one reader_en pulse; 64 valid_o over 64 consecutive cycles; first xr=+724, xi=-724; second sample xr=-724, xi=-724; raw=1 then 0.
- 16QAM, low nibble 0xB -> first xr=+323, xi=+970, raw=0xB; exactly 32 valid_o per word.
- BPSK, two words queued, valid_i held high -> reader_en pulses 128 cycles apart; 256 consecutive valid_o with no gap; xi=0 throughout; xr=+/-1023 following the bits LSB first.
- ce toggling 1,0,1,0 during QPSK -> same 64-sample sequence as the ce=1 run; valid_o low after every ce=0 cycle; reader_en never high while ce=0.
- mode switched QPSK->16QAM at symbol 10 -> remaining 54 samples stay QPSK; next word produces 32 16QAM samples.
- RST_N pulled low at 16QAM symbol 5 -> outputs zero immediately (asynchronous); after release, no residual samples; next word begins at its symbol 0 with t+2 latency.
